// File: rtl/mem_access_if.sv
// mem_access_if: data-memory bus between the MEM stage and the data memory
interface mem_access_if;
    logic        dmemReq;
    logic        dmemWe;
    logic [31:0] dmemAddr;
    logic [31:0] dmemWData;
    logic        dmemAck;
    logic [31:0] dmemRData;
    modport master (output dmemReq, dmemWe, dmemAddr, dmemWData, input dmemAck, dmemRData);
    modport slave (input dmemReq, dmemWe, dmemAddr, dmemWData, output dmemAck, dmemRData);
endinterface

// File: rtl/mem_access.sv
// mem_access: pipeline MEM stage issuing one bus access per load/store, stalling until ack or timeout
module mem_access #(
    parameter int TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                memRegIn,
    input  logic                regWriteIn,
    input  logic                memWriteIn,
    input  logic                memReadIn,
    input  logic [31:0]         aluIn,
    input  logic [4:0]          regWriteAddressIn,
    input  logic [31:0]         memWriteDataIn,
    mem_access_if.master        dmem,
    output logic                memRegOut,
    output logic                regWriteOut,
    output logic [4:0]          regWriteAddressOut,
    output logic [31:0]         aluOut,
    output logic [31:0]         memDataOut,
    output logic                stallOut,
    output logic                misalignOut,
    output logic                busErrOut
);
    localparam int CW = $clog2(TIMEOUT) + 1;
    localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          req_q, req_d, we_q, we_d, berr_q, berr_d;
    logic [31:0]   addr_q, addr_d, wdata_q, wdata_d, mdata_q, mdata_d;
    logic          access, aligned, start, ack, tmo;

    // Next-state logic: ack beats timeout, DONE always returns to IDLE, bus fields frozen while BUSY
    always_comb begin
        access  = memReadIn | memWriteIn;
        aligned = aluIn[1:0] == 2'b00;
        start   = (state_q == IDLE) & access & aligned;
        ack     = (state_q == BUSY) & dmem.dmemAck;
        tmo     = (state_q == BUSY) & !dmem.dmemAck & (cnt_q == CW'(TIMEOUT - 1));
        state_d = start ? BUSY : (ack | tmo) ? DONE : (state_q == BUSY) ? BUSY : IDLE;
        cnt_d   = start ? '0 : (state_q == BUSY) ? cnt_q + CW'(1) : cnt_q;
        req_d   = state_d == BUSY;
        we_d    = start ? memWriteIn : req_d & we_q;
        addr_d  = start ? aluIn : addr_q;
        wdata_d = start ? memWriteDataIn : wdata_q;
        mdata_d = (ack & !we_q) ? dmem.dmemRData : tmo ? 32'd0 : mdata_q;
        berr_d  = tmo;
    end

    // State registers with reset taking priority over any bus event
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            mdata_q <= 32'd0;
            berr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            mdata_q <= mdata_d;
            berr_q  <= berr_d;
        end
    end

    assign dmem.dmemReq       = req_q;
    assign dmem.dmemWe        = we_q;
    assign dmem.dmemAddr      = addr_q;
    assign dmem.dmemWData     = wdata_q;
    assign memDataOut         = mdata_q;
    assign busErrOut          = berr_q;
    assign stallOut           = start | (state_q == BUSY);
    assign misalignOut        = (state_q == IDLE) & access & !aligned;
    assign memRegOut          = memRegIn;
    assign regWriteAddressOut = regWriteAddressIn;
    assign aluOut             = aluIn;
    assign regWriteOut        = regWriteIn & !stallOut & !misalignOut & !busErrOut;
endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: scoreboard bench with random loads/stores, bus responder and reset-abort check
module tb_mem_access;
    localparam int TO = 4;

    typedef struct {
        logic [31:0] data;
        logic        rw;
        logic        berr;
        logic        mis;
        logic        mreg;
        logic [4:0]  wa;
        logic [31:0] alu;
        int          stalls;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
        int          cycles;
    } bus_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic memRegIn = 1'b0, regWriteIn = 1'b0, memWriteIn = 1'b0, memReadIn = 1'b0;
    logic [31:0] aluIn = 32'd0, memWriteDataIn = 32'd0;
    logic [4:0] regWriteAddressIn = 5'd0;
    logic memRegOut, regWriteOut, stallOut, misalignOut, busErrOut;
    logic [4:0] regWriteAddressOut;
    logic [31:0] aluOut, memDataOut;

    exp_t exp_q[$];
    bus_t bus_q[$];
    int errors = 0, checks = 0, issued = 0, retired = 0, stall_cnt = 0;
    int ack_k = 1, rq = 0, rc = 0;
    logic [31:0] ack_data = 32'd0, last_data = 32'd0, force_data = 32'd0;
    logic sb_on = 1'b0, force_ack = 1'b0, prev_req = 1'b0;
    bus_t cur;

    mem_access_if bus();

    mem_access #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .memRegIn(memRegIn), .regWriteIn(regWriteIn), .memWriteIn(memWriteIn), .memReadIn(memReadIn),
        .aluIn(aluIn), .regWriteAddressIn(regWriteAddressIn), .memWriteDataIn(memWriteDataIn),
        .dmem(bus),
        .memRegOut(memRegOut), .regWriteOut(regWriteOut), .regWriteAddressOut(regWriteAddressOut),
        .aluOut(aluOut), .memDataOut(memDataOut),
        .stallOut(stallOut), .misalignOut(misalignOut), .busErrOut(busErrOut)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Memory responder: acks on the k-th request cycle, random ack noise while no request is pending
    always @(negedge clk) begin
        if (!sb_on) begin
            bus.dmemAck   = force_ack;
            bus.dmemRData = force_data;
        end else if (bus.dmemReq) begin
            rq++;
            bus.dmemAck   = rq == ack_k;
            bus.dmemRData = (rq == ack_k) ? ack_data : $urandom;
        end else begin
            rq = 0;
            bus.dmemAck   = 1'($urandom_range(0, 1));
            bus.dmemRData = $urandom;
        end
    end

    // Bus monitor: each request must match the next expected access and stay stable while held
    always @(negedge clk) begin
        if (sb_on) begin
            if (bus.dmemReq) begin
                if (!prev_req) begin
                    rc = 0;
                    if (bus_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_req: got addr %h expected no request", bus.dmemAddr);
                    end else cur = bus_q.pop_front();
                end
                rc++;
                chk("dmemAddr", bus.dmemAddr, cur.addr);
                chk("dmemWe", 32'(bus.dmemWe), 32'(cur.we));
                if (cur.we) chk("dmemWData", bus.dmemWData, cur.wdata);
            end else if (prev_req) chk("req_cycles", rc, cur.cycles);
            prev_req = bus.dmemReq;
        end
    end

    // Retire monitor: whenever the stage stops stalling on a presented instruction, compare with scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (sb_on && issued != retired) begin
            if (stallOut) stall_cnt++;
            else begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL retire_unexpected: got retire expected none");
                end else begin
                    e = exp_q.pop_front();
                    chk("memDataOut", memDataOut, e.data);
                    chk("regWriteOut", 32'(regWriteOut), 32'(e.rw));
                    chk("busErrOut", 32'(busErrOut), 32'(e.berr));
                    chk("misalignOut", 32'(misalignOut), 32'(e.mis));
                    chk("aluOut", aluOut, e.alu);
                    chk("memRegOut", 32'(memRegOut), 32'(e.mreg));
                    chk("regWriteAddressOut", 32'(regWriteAddressOut), 32'(e.wa));
                    chk("stall_cycles", stall_cnt, e.stalls);
                end
                stall_cnt = 0;
                retired++;
            end
        end
    end

    task automatic issue(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                         input logic rw, input logic mreg, input logic [4:0] wa, input int k,
                         input logic [31:0] rdat);
        exp_t e;
        bus_t b;
        int n;
        e.alu = addr; e.mreg = mreg; e.wa = wa; e.mis = 1'b0; e.berr = 1'b0;
        e.rw = rw; e.data = last_data; e.stalls = 0;
        if (rd | wr) begin
            if (addr[1:0] != 2'b00) begin
                e.mis = 1'b1;
                e.rw  = 1'b0;
            end else begin
                n = (k <= TO) ? k : TO;
                b.addr = addr; b.wdata = wd; b.we = wr; b.cycles = n;
                bus_q.push_back(b);
                e.stalls = n + 1;
                if (k > TO) begin
                    e.berr = 1'b1;
                    e.rw   = 1'b0;
                    e.data = 32'd0;
                end else if (!wr) e.data = rdat;
                last_data = e.data;
            end
        end
        exp_q.push_back(e);
        ack_k = k;
        ack_data = rdat;
        memReadIn = rd; memWriteIn = wr; aluIn = addr; memWriteDataIn = wd;
        regWriteIn = rw; memRegIn = mreg; regWriteAddressIn = wa;
        issued++;
        for (int c = 0; c < 40 && retired != issued; c++) @(posedge clk);
        if (retired != issued) begin
            checks++;
            errors++;
            $display("FAIL retire_timeout: got %0d retired expected %0d", retired, issued);
        end
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dmemReq", 32'(bus.dmemReq), 32'd0);
        chk("rst_dmemWe", 32'(bus.dmemWe), 32'd0);
        chk("rst_dmemAddr", bus.dmemAddr, 32'd0);
        chk("rst_dmemWData", bus.dmemWData, 32'd0);
        chk("rst_memDataOut", memDataOut, 32'd0);
        chk("rst_busErrOut", 32'(busErrOut), 32'd0);
        chk("rst_stallOut", 32'(stallOut), 32'd0);
        reset = 1'b0;
        sb_on = 1'b1;
        @(posedge clk);
        #1;
        issue(1, 0, 32'h100, 32'h0, 1, 1, 5'd3, 2, 32'hDEADBEEF);
        issue(0, 1, 32'h204, 32'h12345678, 0, 0, 5'd0, 1, 32'h0BADF00D);
        issue(1, 0, 32'h102, 32'h0, 1, 1, 5'd4, 1, 32'h11111111);
        issue(1, 0, 32'h40, 32'h0, 1, 1, 5'd7, 9, 32'h22222222);
        issue(1, 0, 32'h44, 32'h0, 1, 0, 5'd8, 4, 32'h33333333);
        issue(1, 0, 32'h0, 32'h0, 1, 1, 5'd9, 1, 32'hA5A5A5A5);
        issue(1, 0, 32'h4, 32'h0, 1, 1, 5'd10, 1, 32'h5A5A5A5A);
        issue(0, 0, 32'h77, 32'h0, 1, 0, 5'd11, 1, 32'h0);
        issue(1, 1, 32'h80, 32'hFEEDFACE, 0, 0, 5'd12, 3, 32'h44444444);
        for (int i = 0; i < 60; i++) begin
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                  $urandom_range(1, 6), $urandom);
        end
        sb_on = 1'b0;
        force_ack = 1'b0;
        memReadIn = 1'b1; memWriteIn = 1'b0; aluIn = 32'h300; regWriteIn = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_busy_req", 32'(bus.dmemReq), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_req", 32'(bus.dmemReq), 32'd0);
        chk("abort_memDataOut", memDataOut, 32'd0);
        chk("abort_busErrOut", 32'(busErrOut), 32'd0);
        reset = 1'b0;
        memReadIn = 1'b0;
        force_ack = 1'b1;
        force_data = 32'hCAFEF00D;
        @(posedge clk);
        #1;
        force_ack = 1'b0;
        chk("late_ack_memDataOut", memDataOut, 32'd0);
        chk("late_ack_req", 32'(bus.dmemReq), 32'd0);
        chk("late_ack_stall", 32'(stallOut), 32'd0);
        chk("late_ack_regWriteOut", 32'(regWriteOut), 32'd1);
        @(posedge clk);
        #1;
        chk("idle_req", 32'(bus.dmemReq), 32'd0);
        chk("idle_memDataOut", memDataOut, 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15: max cycles in BUSY awaiting dmemAck before abort.
REQ-002 SHALL have clk  input  1: single clock; all state updates on rising edge.
REQ-003 SHALL have reset  input  1: synchronous, active-high.
REQ-004 SHALL have memRegIn, regWriteIn, memWriteIn, memReadIn  input  1 each: control from EX/MEM register.
REQ-005 SHALL have aluIn  input  32: access address / ALU result; regWriteAddressIn  input  5; memWriteDataIn  input  32: store data.
REQ-006 SHALL have dmemReq, dmemWe  output  1; dmemAddr, dmemWData  output  32: data-memory bus request.
REQ-007 SHALL have dmemAck  input  1; dmemRData  input  32: bus completion and read data.
REQ-008 SHALL have memRegOut, regWriteOut  output  1; regWriteAddressOut  output  5; aluOut, memDataOut  output  32: to MEM/WB register.
REQ-009 SHALL have stallOut  output  1: hold EX/MEM and earlier stages; misalignOut, busErrOut  output  1: exception flags.

Function
REQ-010 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-011 access = memReadIn | memWriteIn; aligned = (aluIn[1:0] == 2'b00).
REQ-012 IDLE, access & aligned: next state BUSY; latch dmemAddr=aluIn, dmemWData=memWriteDataIn, dmemWe=memWriteIn; dmemReq=1 from next cycle.
REQ-013 memReadIn & memWriteIn both set: SHALL be treated as write (dmemWe=1).
REQ-014 IDLE, access & !aligned: no bus request, state stays IDLE, misalignOut=1 (combinational), no stall.
REQ-015 BUSY: dmemReq, dmemAddr, dmemWData, dmemWe SHALL stay constant; wait counter increments each cycle.
REQ-016 BUSY & dmemAck: capture dmemRData into memDataOut if read (memDataOut unchanged on write); dmemReq=0 next cycle; go DONE.
REQ-017 BUSY & !dmemAck & counter == TIMEOUT-1: go DONE, memDataOut=0, busErrOut=1 for the DONE cycle only, dmemReq=0 next cycle.
REQ-018 Ack and timeout in the same cycle: ack SHALL win, busErrOut stays 0.
REQ-019 DONE: next state IDLE unconditionally; no new access starts in DONE even if access=1 (same instruction still presented).
REQ-020 stallOut = (IDLE & access & aligned) | BUSY; SHALL be 0 in DONE and for non-access or misaligned instructions.
REQ-021 Access latency: request in IDLE at cycle N, ack at N+k (k>=1) -> DONE at N+k+1, stallOut low from N+k+1.
REQ-022 memRegOut, regWriteAddressOut, aluOut SHALL pass through combinationally from inputs.
REQ-023 regWriteOut = regWriteIn & !stallOut & !misalignOut & !busErrOut.
REQ-024 memDataOut SHALL hold its last captured value in IDLE and DONE.
REQ-025 dmemAck in IDLE or DONE SHALL be ignored.
REQ-026 Counter SHALL clear on entry to BUSY; width ceil(log2(TIMEOUT))+1.

Reset
REQ-027 reset SHALL force state IDLE, counter 0, dmemReq 0, dmemWe 0, dmemAddr 0, dmemWData 0, memDataOut 0, busErrOut 0 at next edge.
REQ-028 reset asserted in BUSY SHALL abandon the access: dmemReq low after the reset edge, a late dmemAck ignored.
REQ-029 reset SHALL take priority over every other event in the same cycle.

Verification
REQ-030 Load: memReadIn=1, aluIn=0x100, dmemAck after 2 cycles with dmemRData=0xDEADBEEF -> dmemReq high 2 cycles, stallOut high 3 cycles, memDataOut=0xDEADBEEF, regWriteOut=1 in DONE.
REQ-031 Store: memWriteIn=1, aluIn=0x204, memWriteDataIn=0x12345678, immediate ack -> dmemWe=1, dmemAddr=0x204, dmemWData=0x12345678 for 1 cycle; memDataOut unchanged.
REQ-032 Misaligned: memReadIn=1, aluIn=0x102 -> misalignOut=1, dmemReq stays 0, stallOut=0, regWriteOut=0.
REQ-033 Timeout: TIMEOUT=4, no ack -> BUSY 4 cycles, then DONE with busErrOut=1, memDataOut=0, regWriteOut=0; ack on the 4th BUSY cycle -> no error.
REQ-034 Reset in BUSY: reset after 1 BUSY cycle, ack the following cycle -> IDLE, dmemReq=0, memDataOut=0, ack ignored.
REQ-035 Back-to-back loads at 0x0 then 0x4, 1-cycle ack each -> two distinct bus requests, no request in DONE, correct data each.
